// File: rtl/lab6_soc_pio_pkg.sv
// rtl/lab6_soc_pio_pkg.sv - register addresses and pulse FSM state type for the output PIO
package lab6_soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/lab6_soc_pulse_pio_out_if.sv
// rtl/lab6_soc_pulse_pio_out_if.sv - Avalon-MM slave bus bundle for the output PIO
interface lab6_soc_pulse_pio_out_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/lab6_soc_pulse_timer.sv
// rtl/lab6_soc_pulse_timer.sv - loadable one-shot down-counter with registered busy flag
module lab6_soc_pulse_timer
  import lab6_soc_pio_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  pulse_state_t state;

  // A load always wins over expiry so a restart in the final cycle leaves no gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      if (len != '0) begin
        state <= ST_PULSE;
        count <= len;
        busy  <= 1'b1;
      end else begin
        state <= ST_IDLE;
        count <= '0;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        ST_PULSE: begin
          if (count == CNT_W'(1)) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lab6_soc_pulse_pio_out.sv
// rtl/lab6_soc_pulse_pio_out.sv - output PIO with set/clear registers and masked one-shot pulse
module lab6_soc_pulse_pio_out
  import lab6_soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  lab6_soc_pulse_pio_out_if.slave     bus,
  output logic [WIDTH-1:0]            out_port
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] wd;
  logic             wr;
  logic             pulse_load;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic [31:0]      rd_next;
  logic             unused_wd;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wd         = bus.writedata[WIDTH-1:0];
  assign pulse_load = wr && (bus.address == ADDR_PULSE_LEN);
  assign unused_wd  = &{1'b0, bus.writedata[31:CNT_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
      mask_reg <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:     data_reg <= wd;
        ADDR_MASK:     mask_reg <= wd;
        ADDR_OUTSET:   data_reg <= data_reg | wd;
        ADDR_OUTCLEAR: data_reg <= data_reg & ~wd;
        default:       ;
      endcase
    end
  end

  lab6_soc_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pulse_load),
    .len     (bus.writedata[CNT_W-1:0]),
    .busy    (busy),
    .count   (count)
  );

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:      rd_next[WIDTH-1:0] = data_reg;
      ADDR_MASK:      rd_next[WIDTH-1:0] = mask_reg;
      ADDR_PULSE_LEN: rd_next[CNT_W-1:0] = count;
      ADDR_STATUS:    rd_next[0]         = busy;
      default:        rd_next            = '0;
    endcase
  end

  // Read data is sampled every cycle regardless of chipselect; the master ignores it when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign out_port = data_reg | (busy ? mask_reg : '0);

endmodule

// File: tb/tb_lab6_soc_pulse_pio_out.sv
// tb/tb_lab6_soc_pulse_pio_out.sv - directed self-checking bench for the output PIO
module tb_lab6_soc_pulse_pio_out;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         n_checks;
  int         n_fail;

  lab6_soc_pulse_pio_out_if bus ();

  lab6_soc_pulse_pio_out #(
    .WIDTH       (8),
    .CNT_W       (24),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic cs);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out_port got %h want a5", out_port); end
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", bus.readdata); end
    reset_n     = 1'b1;
    bus.address = 3'd3;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", bus.readdata); end
    bus.address = 3'd0;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'hA5) begin n_fail++; $display("FAIL reset_data_read got %h want a5", bus.readdata); end
  endtask

  task automatic test_data_set_clear();
    bus_write(3'd0, 32'hFFFF_FF0F, 1'b1);
    n_checks++;
    if (out_port !== 8'h0F) begin n_fail++; $display("FAIL data_write got %h want 0f", out_port); end
    bus_write(3'd4, 32'h30, 1'b1);
    n_checks++;
    if (out_port !== 8'h3F) begin n_fail++; $display("FAIL outset got %h want 3f", out_port); end
    bus_write(3'd5, 32'h03, 1'b1);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL outclear got %h want 3c", out_port); end
    bus.address = 3'd0;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h3C) begin n_fail++; $display("FAIL data_read got %h want 3c", bus.readdata); end
    bus.address = 3'd4;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL outset_read got %h want 0", bus.readdata); end
  endtask

  task automatic test_pulse();
    logic [31:0] exp_rd;
    bus_write(3'd1, 32'h80, 1'b1);
    bus_write(3'd2, 32'h5, 1'b1);
    for (int j = 0; j <= 6; j++) begin
      n_checks++;
      if (out_port !== ((j < 5) ? 8'hBC : 8'h3C)) begin
        n_fail++; $display("FAIL pulse_out cycle %0d got %h want %h", j, out_port, (j < 5) ? 8'hBC : 8'h3C);
      end
      if (j >= 1) begin
        exp_rd = (j <= 5) ? 32'(6 - j) : 32'h0;
        n_checks++;
        if (bus.readdata !== exp_rd) begin
          n_fail++; $display("FAIL pulse_count cycle %0d got %0d want %0d", j, bus.readdata, exp_rd);
        end
      end
      @(negedge clk);
    end
    bus.address = 3'd3;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL pulse_busy_end got %h want 0", bus.readdata); end
  endtask

  task automatic test_restart();
    bus_write(3'd2, 32'h5, 1'b1);
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (out_port !== 8'hBC) begin n_fail++; $display("FAIL restart_pre cycle %0d got %h want bc", j, out_port); end
      @(negedge clk);
    end
    bus_write(3'd2, 32'hFF00_000A, 1'b1);
    for (int j = 0; j <= 10; j++) begin
      n_checks++;
      if (out_port !== ((j < 10) ? 8'hBC : 8'h3C)) begin
        n_fail++; $display("FAIL restart_out cycle %0d got %h want %h", j, out_port, (j < 10) ? 8'hBC : 8'h3C);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort_and_ignored();
    bus_write(3'd2, 32'd20, 1'b1);
    @(negedge clk);
    bus.address = 3'd3;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h1) begin n_fail++; $display("FAIL abort_busy got %h want 1", bus.readdata); end
    bus_write(3'd2, 32'h0, 1'b1);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL abort_out got %h want 3c", out_port); end
    bus.address = 3'd3;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL abort_status got %h want 0", bus.readdata); end
    bus_write(3'd0, 32'hFF, 1'b0);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL cs_low_data got %h want 3c", out_port); end
    bus_write(3'd2, 32'h7, 1'b0);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL cs_low_pulse got %h want 3c", out_port); end
    bus_write(3'd6, 32'hFF, 1'b1);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL reserved_write got %h want 3c", out_port); end
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reserved_read got %h want 0", bus.readdata); end
  endtask

  task automatic test_mask_update();
    bus_write(3'd2, 32'd8, 1'b1);
    n_checks++;
    if (out_port !== 8'hBC) begin n_fail++; $display("FAIL mask_pre got %h want bc", out_port); end
    bus_write(3'd1, 32'h01, 1'b1);
    n_checks++;
    if (out_port !== 8'h3D) begin n_fail++; $display("FAIL mask_live got %h want 3d", out_port); end
    bus_write(3'd2, 32'h0, 1'b1);
    bus_write(3'd1, 32'h84, 1'b1);
    bus_write(3'd2, 32'd2, 1'b1);
    n_checks++;
    if (out_port !== 8'hBC) begin n_fail++; $display("FAIL overlap_busy got %h want bc", out_port); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_port !== 8'h3C) begin n_fail++; $display("FAIL overlap_after got %h want 3c", out_port); end
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(3'd1, 32'h80, 1'b1);
    bus_write(3'd2, 32'd100, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_port !== 8'hBC) begin n_fail++; $display("FAIL midreset_pre got %h want bc", out_port); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL midreset_out got %h want a5", out_port); end
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_rd got %h want 0", bus.readdata); end
    @(negedge clk);
    reset_n     = 1'b1;
    bus.address = 3'd3;
    @(negedge clk);
    n_checks++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_busy got %h want 0", bus.readdata); end
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL midreset_after got %h want a5", out_port); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_data_set_clear();
    test_pulse();
    test_restart();
    test_abort_and_ignored();
    test_mask_update();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
